// File: rtl/icache_pkg.sv
// Shared geometry constants, FSM encoding and small address helpers for the icache refill path.
package icache_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned INDEX_W  = 8;
    localparam int unsigned BEATS    = 4;
    localparam int unsigned BEAT_W   = $clog2(BEATS);
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned RAM_AW   = INDEX_W + BEAT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    // One data RAM write: word address {index, beat} and payload
    typedef struct packed {
        logic [RAM_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } ram_wr_t;

    // Line index taken from a byte address
    function automatic logic [INDEX_W-1:0] line_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    // Line-aligned byte address (offset bits cleared)
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Core read port, refill handshake, bus burst channel and data RAM port of the refill controller.
interface icache_refill_ctrl_if;
    import icache_pkg::*;

    logic                rd_req_i;
    logic [RAM_AW-1:0]   rd_addr_i;
    logic                rd_gnt_o;
    logic                rd_valid_o;

    logic                refill_req_i;
    logic [ADDR_W-1:0]   refill_addr_i;
    logic                refill_busy_o;
    logic                refill_done_o;
    logic                refill_err_o;

    logic                bus_req_o;
    logic [ADDR_W-1:0]   bus_addr_o;
    logic                bus_gnt_i;
    logic                bus_rvalid_i;
    logic [DATA_W-1:0]   bus_rdata_i;
    logic                bus_rlast_i;
    logic                bus_err_i;

    logic [RAM_AW-1:0]   ram_addr_o;
    logic [DATA_W-1:0]   ram_wdata_o;
    logic                ram_wr_o;

    // Controller side
    modport slave (
        input  rd_req_i, rd_addr_i,
        output rd_gnt_o, rd_valid_o,
        input  refill_req_i, refill_addr_i,
        output refill_busy_o, refill_done_o, refill_err_o,
        output bus_req_o, bus_addr_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_rlast_i, bus_err_i,
        output ram_addr_o, ram_wdata_o, ram_wr_o
    );

    // Environment side (core, tag logic, bus, RAM)
    modport master (
        output rd_req_i, rd_addr_i,
        input  rd_gnt_o, rd_valid_o,
        output refill_req_i, refill_addr_i,
        input  refill_busy_o, refill_done_o, refill_err_o,
        input  bus_req_o, bus_addr_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_rlast_i, bus_err_i,
        input  ram_addr_o, ram_wdata_o, ram_wr_o
    );

endinterface

// File: rtl/icache_ram_arb.sv
// Data RAM port mux: refill writes win, core reads are blocked on the line being refilled.
module icache_ram_arb
    import icache_pkg::*;
(
    input  logic                i_fill_wr,
    input  ram_wr_t             i_fill,
    input  logic                i_busy,
    input  logic [INDEX_W-1:0]  i_index,
    input  logic                i_rd_req,
    input  logic [RAM_AW-1:0]   i_rd_addr,
    output logic                o_rd_gnt_c,
    output logic [RAM_AW-1:0]   o_ram_addr_c,
    output logic [DATA_W-1:0]   o_ram_wdata_c,
    output logic                o_ram_wr_c
);

    logic w_hazard;

    // A read of the line under refill would return a partially filled line
    assign w_hazard = i_busy & (i_rd_addr[RAM_AW-1:BEAT_W] == i_index);

    // Grant and RAM port steering
    always_comb begin
        o_rd_gnt_c    = i_rd_req & ~i_fill_wr & ~w_hazard;
        o_ram_addr_c  = i_rd_addr;
        o_ram_wdata_c = '0;
        o_ram_wr_c    = 1'b0;
        if (i_fill_wr) begin
            o_ram_addr_c  = i_fill.addr;
            o_ram_wdata_c = i_fill.data;
            o_ram_wr_c    = 1'b1;
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Icache line refill controller: runs the bus read burst for a miss and shares the data RAM with core reads.
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    icache_refill_ctrl_if.slave  bus_if
);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [BEAT_W-1:0]    r_cnt;
    logic                 r_over;
    logic                 r_err;
    logic [INDEX_W-1:0]   r_index;
    logic [ADDR_W-1:0]    r_bus_addr;
    logic                 r_rd_valid;

    logic                 w_busy;
    logic                 w_bus_req;
    logic                 w_done;
    logic                 w_fill_wr;
    logic                 w_beat_err;
    logic                 w_last_slot;
    logic                 w_rd_gnt;
    ram_wr_t              w_fill;
    logic                 w_unused;

    assign w_last_slot = (r_cnt == BEAT_W'(BEATS - 1));
    assign w_fill      = '{addr: {r_index, r_cnt}, data: bus_if.bus_rdata_i};
    assign w_unused    = ^bus_if.refill_addr_i[OFFSET_W-1:0];

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (bus_if.refill_req_i) w_state_nxt = REQ;
            REQ:  if (bus_if.bus_gnt_i)    w_state_nxt = FILL;
            FILL: if (bus_if.bus_rvalid_i && (bus_if.bus_rlast_i || bus_if.bus_err_i))
                      w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State decode: handshake outputs, beat write enable and beat error detection
    always_comb begin
        w_busy     = 1'b0;
        w_bus_req  = 1'b0;
        w_done     = 1'b0;
        w_fill_wr  = 1'b0;
        w_beat_err = 1'b0;
        case (r_state)
            REQ: begin
                w_busy    = 1'b1;
                w_bus_req = 1'b1;
            end
            FILL: begin
                w_busy     = 1'b1;
                w_fill_wr  = bus_if.bus_rvalid_i & ~r_over;
                w_beat_err = bus_if.bus_rvalid_i &
                             (bus_if.bus_err_i | r_over | (bus_if.bus_rlast_i & ~w_last_slot));
            end
            DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Miss latch, beat counter, overflow flag and sticky error
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_index    <= '0;
            r_bus_addr <= '0;
            r_cnt      <= '0;
            r_over     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == IDLE && bus_if.refill_req_i) begin
                r_index    <= line_index(bus_if.refill_addr_i);
                r_bus_addr <= line_base(bus_if.refill_addr_i);
                r_err      <= 1'b0;
            end
            if (r_state == REQ && bus_if.bus_gnt_i) begin
                r_cnt  <= '0;
                r_over <= 1'b0;
            end
            if (w_fill_wr) begin
                r_cnt <= BEAT_W'(r_cnt + 1'b1);
                if (w_last_slot) begin
                    r_over <= 1'b1;
                end
            end
            if (w_beat_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Read data is valid the cycle after its grant
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_gnt;
        end
    end

    icache_ram_arb u_ram_arb (
        .i_fill_wr     (w_fill_wr),
        .i_fill        (w_fill),
        .i_busy        (w_busy),
        .i_index       (r_index),
        .i_rd_req      (bus_if.rd_req_i),
        .i_rd_addr     (bus_if.rd_addr_i),
        .o_rd_gnt_c    (w_rd_gnt),
        .o_ram_addr_c  (bus_if.ram_addr_o),
        .o_ram_wdata_c (bus_if.ram_wdata_o),
        .o_ram_wr_c    (bus_if.ram_wr_o)
    );

    assign bus_if.rd_gnt_o      = w_rd_gnt;
    assign bus_if.rd_valid_o    = r_rd_valid;
    assign bus_if.refill_busy_o = w_busy;
    assign bus_if.refill_done_o = w_done;
    assign bus_if.refill_err_o  = w_done & r_err;
    assign bus_if.bus_req_o     = w_bus_req;
    assign bus_if.bus_addr_o    = r_bus_addr;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with a data RAM model and write/read scoreboards.
module tb_icache_refill_ctrl;

    logic clk;
    logic rst_n;

    icache_refill_ctrl_if bus_if();

    icache_refill_ctrl dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus_if  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data RAM model: single port, registered read
    logic [63:0] mem [1024];
    logic [63:0] ram_rdata;
    always @(posedge clk) begin
        if (bus_if.ram_wr_o) mem[bus_if.ram_addr_o] <= bus_if.ram_wdata_o;
        ram_rdata <= mem[bus_if.ram_addr_o];
    end

    typedef struct { logic [9:0] a; logic [63:0] d; } wexp_t;
    typedef struct { bit ok; logic [63:0] d; } rexp_t;

    wexp_t       wq[$];
    rexp_t       rq[$];
    logic [63:0] exp_mem [1024];
    bit          exp_ok  [1024];

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    logic s_gnt, s_rdv, s_wr, s_busy, s_done, s_err, s_breq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Snapshot outputs and run the write/read scoreboards
    task automatic sample();
        wexp_t w;
        rexp_t r;
        s_gnt  = bus_if.rd_gnt_o;
        s_rdv  = bus_if.rd_valid_o;
        s_wr   = bus_if.ram_wr_o;
        s_busy = bus_if.refill_busy_o;
        s_done = bus_if.refill_done_o;
        s_err  = bus_if.refill_err_o;
        s_breq = bus_if.bus_req_o;
        if (s_rdv) begin
            chk("rd_pending", 64'(rq.size() > 0), 64'(1));
            if (rq.size() > 0) begin
                r = rq.pop_front();
                if (r.ok) chk("rd_data", ram_rdata, r.d);
            end
        end
        if (s_gnt) rq.push_back('{exp_ok[bus_if.rd_addr_i], exp_mem[bus_if.rd_addr_i]});
        if (s_wr) begin
            chk("wr_pending", 64'(wq.size() > 0), 64'(1));
            if (wq.size() > 0) begin
                w = wq.pop_front();
                chk("wr_addr", 64'(bus_if.ram_addr_o), 64'(w.a));
                chk("wr_data", bus_if.ram_wdata_o, w.d);
            end
        end
        if (s_done) n_done++;
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic last, input logic err,
                        input logic wr_exp, input logic [9:0] a);
        bus_if.bus_rvalid_i = 1'b1;
        bus_if.bus_rdata_i  = d;
        bus_if.bus_rlast_i  = last;
        bus_if.bus_err_i    = err;
        if (wr_exp) begin
            wq.push_back('{a, d});
            exp_mem[a] = d;
            exp_ok[a]  = 1'b1;
        end
        cycle();
        bus_if.bus_rvalid_i = 1'b0;
        bus_if.bus_rdata_i  = '0;
        bus_if.bus_rlast_i  = 1'b0;
        bus_if.bus_err_i    = 1'b0;
    endtask

    // IDLE request cycle, ndly REQ cycles without grant, then the grant cycle
    task automatic start_refill(input logic [31:0] addr, input int ndly, input bit hz);
        bus_if.refill_req_i  = 1'b1;
        bus_if.refill_addr_i = addr;
        cycle();
        bus_if.refill_req_i = 1'b0;
        if (hz) bus_if.rd_req_i = 1'b1;
        for (int i = 0; i < ndly; i++) begin
            cycle();
            chk("req_bus_req", 64'(s_breq), 64'(1));
            chk("req_busy", 64'(s_busy), 64'(1));
            if (hz) chk("hz_gnt_req", 64'(s_gnt), 64'(0));
        end
        chk("bus_addr", 64'(bus_if.bus_addr_o), 64'(addr & 32'hFFFF_FFE0));
        bus_if.bus_gnt_i = 1'b1;
        cycle();
        chk("gnt_bus_req", 64'(s_breq), 64'(1));
        bus_if.bus_gnt_i = 1'b0;
    endtask

    // DONE cycle then the following IDLE cycle
    task automatic finish_done(input bit exp_err, input bit hz);
        cycle();
        chk("done_pulse", 64'(s_done), 64'(1));
        chk("done_err", 64'(s_err), 64'(exp_err));
        chk("done_busy", 64'(s_busy), 64'(1));
        if (hz) chk("hz_gnt_done", 64'(s_gnt), 64'(0));
        cycle();
        chk("idle_done", 64'(s_done), 64'(0));
        chk("idle_busy", 64'(s_busy), 64'(0));
        if (hz) chk("hz_gnt_idle", 64'(s_gnt), 64'(1));
    endtask

    initial begin
        logic prev_gnt;
        int   done_before;

        rst_n                = 1'b0;
        bus_if.rd_req_i      = 1'b0;
        bus_if.rd_addr_i     = '0;
        bus_if.refill_req_i  = 1'b0;
        bus_if.refill_addr_i = '0;
        bus_if.bus_gnt_i     = 1'b0;
        bus_if.bus_rvalid_i  = 1'b0;
        bus_if.bus_rdata_i   = '0;
        bus_if.bus_rlast_i   = 1'b0;
        bus_if.bus_err_i     = 1'b0;

        // Reset state
        cycle();
        chk("rst_busy", 64'(s_busy), 64'(0));
        chk("rst_done", 64'(s_done), 64'(0));
        chk("rst_err", 64'(s_err), 64'(0));
        chk("rst_bus_req", 64'(s_breq), 64'(0));
        chk("rst_bus_addr", 64'(bus_if.bus_addr_o), 64'(0));
        chk("rst_ram_wr", 64'(s_wr), 64'(0));
        chk("rst_ram_wdata", bus_if.ram_wdata_o, 64'(0));
        chk("rst_rd_valid", 64'(s_rdv), 64'(0));
        rst_n = 1'b1;

        // Clean refill of line 0xD2, then read back beat 2
        start_refill(32'h0000_1A40, 2, 1'b0);
        for (int i = 0; i < 4; i++)
            beat(64'hD0D0_0000_0000_0000 + 64'(i), 1'(i == 3), 1'b0, 1'b1, 10'(10'h348 + i));
        finish_done(1'b0, 1'b0);
        bus_if.rd_req_i  = 1'b1;
        bus_if.rd_addr_i = 10'h34A;
        cycle();
        chk("clean_rd_gnt", 64'(s_gnt), 64'(1));
        bus_if.rd_req_i = 1'b0;
        cycle();
        chk("clean_rd_valid", 64'(s_rdv), 64'(1));

        // Contention: read of 0x010 held while beats arrive every other cycle
        bus_if.rd_req_i  = 1'b1;
        bus_if.rd_addr_i = 10'h010;
        start_refill(32'h0000_3C80, 1, 1'b0);
        prev_gnt = s_gnt;
        for (int i = 0; i < 4; i++) begin
            beat(64'hC0C0_0000_0000_0000 + 64'(i), 1'(i == 3), 1'b0, 1'b1, 10'(10'h390 + i));
            chk("cont_gnt_beat", 64'(s_gnt), 64'(0));
            chk("cont_rdv_beat", 64'(s_rdv), 64'(prev_gnt));
            prev_gnt = s_gnt;
            if (i < 3) begin
                cycle();
                chk("cont_gnt_gap", 64'(s_gnt), 64'(1));
                chk("cont_rdv_gap", 64'(s_rdv), 64'(prev_gnt));
                prev_gnt = s_gnt;
            end
        end
        bus_if.rd_req_i = 1'b0;
        finish_done(1'b0, 1'b0);

        // Hazard: read of 0x349 blocked for the whole refill of line 0xD2
        bus_if.rd_addr_i = 10'h349;
        start_refill(32'h0000_1A40, 1, 1'b1);
        chk("hz_gnt_gntcyc", 64'(s_gnt), 64'(0));
        for (int i = 0; i < 4; i++) begin
            beat(64'hE0E0_0000_0000_0000 + 64'(i), 1'(i == 3), 1'b0, 1'b1, 10'(10'h348 + i));
            chk("hz_gnt_beat", 64'(s_gnt), 64'(0));
            if (i == 1) begin
                cycle();
                chk("hz_gnt_gap", 64'(s_gnt), 64'(0));
            end
        end
        finish_done(1'b0, 1'b1);
        bus_if.rd_req_i = 1'b0;
        cycle();
        chk("hz_rd_valid", 64'(s_rdv), 64'(1));

        // Bus error on beat 2; stray beats afterwards must not write
        start_refill(32'h0000_4000, 0, 1'b0);
        beat(64'hB0B0_0000_0000_0000, 1'b0, 1'b0, 1'b1, 10'h000);
        beat(64'hB0B0_0000_0000_0001, 1'b0, 1'b1, 1'b1, 10'h001);
        bus_if.bus_rvalid_i = 1'b1;
        bus_if.bus_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
        finish_done(1'b1, 1'b0);
        bus_if.bus_rvalid_i = 1'b0;
        bus_if.bus_rdata_i  = '0;

        // Short burst: rlast on beat 3
        start_refill(32'h0000_5000, 1, 1'b0);
        for (int i = 0; i < 3; i++)
            beat(64'hA0A0_0000_0000_0000 + 64'(i), 1'(i == 2), 1'b0, 1'b1, 10'(10'h200 + i));
        finish_done(1'b1, 1'b0);

        // Long burst: beats 5 and 6 are dropped, rlast on beat 6 ends it
        start_refill(32'h0000_6038, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            beat(64'h9090_0000_0000_0000 + 64'(i), 1'b0, 1'b0, 1'b1, 10'(10'h004 + i));
            chk("long_busy", 64'(s_busy), 64'(1));
        end
        beat(64'h9090_0000_0000_0004, 1'b0, 1'b0, 1'b0, 10'h0);
        chk("long_b5_wr", 64'(s_wr), 64'(0));
        chk("long_b5_done", 64'(s_done), 64'(0));
        beat(64'h9090_0000_0000_0005, 1'b1, 1'b0, 1'b0, 10'h0);
        chk("long_b6_wr", 64'(s_wr), 64'(0));
        finish_done(1'b1, 1'b0);

        // Async reset after beat 2, then a clean refill of the same line
        start_refill(32'h0000_7000, 0, 1'b0);
        beat(64'h8080_0000_0000_0000, 1'b0, 1'b0, 1'b1, 10'h200);
        beat(64'h8080_0000_0000_0001, 1'b0, 1'b0, 1'b1, 10'h201);
        done_before = n_done;
        bus_if.bus_rvalid_i = 1'b1;
        bus_if.bus_rdata_i  = 64'h8080_0000_0000_0002;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(bus_if.refill_busy_o), 64'(0));
        chk("arst_bus_req", 64'(bus_if.bus_req_o), 64'(0));
        chk("arst_ram_wr", 64'(bus_if.ram_wr_o), 64'(0));
        chk("arst_done", 64'(bus_if.refill_done_o), 64'(0));
        chk("arst_bus_addr", 64'(bus_if.bus_addr_o), 64'(0));
        chk("arst_rd_valid", 64'(bus_if.rd_valid_o), 64'(0));
        cycle();
        chk("arst_hold_wr", 64'(s_wr), 64'(0));
        chk("arst_no_done", 64'(n_done), 64'(done_before));
        bus_if.bus_rvalid_i = 1'b0;
        bus_if.bus_rdata_i  = '0;
        rst_n = 1'b1;
        start_refill(32'h0000_7000, 0, 1'b0);
        for (int i = 0; i < 4; i++)
            beat(64'h7070_0000_0000_0000 + 64'(i), 1'(i == 3), 1'b0, 1'b1, 10'(10'h200 + i));
        finish_done(1'b0, 1'b0);
        bus_if.rd_req_i  = 1'b1;
        bus_if.rd_addr_i = 10'h202;
        cycle();
        chk("post_rst_rd_gnt", 64'(s_gnt), 64'(1));
        bus_if.rd_req_i = 1'b0;
        cycle();
        chk("post_rst_rd_valid", 64'(s_rdv), 64'(1));

        // Closing bookkeeping
        cycle();
        chk("wq_drained", 64'(wq.size()), 64'(0));
        chk("rq_drained", 64'(rq.size()), 64'(0));
        chk("done_count", 64'(n_done), 64'(7));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
